ptp_up_regs: RTL and testbench

//  CPU-side register slave; consumes the up_wr/up_rd/up_addr/up_data_wr bus driven by the host CPU (BFM in sim).

---
 rtl/ptp_pkg.sv | 40 ++++
 rtl/ptp_tsq_fifo.sv | 55 +++++
 rtl/ptp_up_regs.sv | 191 +++++++++++++++++++
 tb/tb_ptp_up_regs.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_pkg.sv
// Shared constants for the PTP CPU register slave: register map, CTRL bits,
// reset values, timestamp field layout and the snapshot FSM state type.
package ptp_pkg;

  localparam logic [7:0] A_CTRL     = 8'h00;
  localparam logic [7:0] A_TSEC_H   = 8'h10;
  localparam logic [7:0] A_TSEC_L   = 8'h14;
  localparam logic [7:0] A_TNS      = 8'h18;
  localparam logic [7:0] A_PERIOD   = 8'h1C;
  localparam logic [7:0] A_ADJ      = 8'h20;
  localparam logic [7:0] A_SSEC_H   = 8'h24;
  localparam logic [7:0] A_SSEC_L   = 8'h28;
  localparam logic [7:0] A_SNS      = 8'h2C;
  localparam logic [7:0] A_TSQ_STAT = 8'h30;
  localparam logic [7:0] A_TSQ_W0   = 8'h34;
  localparam logic [7:0] A_TSQ_W1   = 8'h38;
  localparam logic [7:0] A_TSQ_W2   = 8'h3C;

  localparam int CTRL_SET  = 0;
  localparam int CTRL_ADJ  = 1;
  localparam int CTRL_SNAP = 2;
  localparam int CTRL_BUSY = 3;
  localparam int STAT_OVF  = 31;

  // 8 ns per clock in 8.24 fixed point
  localparam logic [31:0] PERIOD_RST = 32'h0800_0000;

  // ts_data = {seqid[15:0], sec[47:0], 2'b0, ns[29:0]}
  localparam int TS_W       = 96;
  localparam int TS_NS_LSB  = 0;
  localparam int TS_NS_W    = 30;
  localparam int TS_SEC_LSB = 32;
  localparam int TS_SEQ_LSB = 80;

  typedef enum logic {
    SNAP_IDLE = 1'b0,
    SNAP_REQ  = 1'b1
  } snap_state_t;

endpackage

// File: rtl/ptp_tsq_fifo.sv
// Synchronous timestamp FIFO. A push into a full FIFO is dropped unless a pop
// happens in the same cycle; a pop from an empty FIFO is ignored.
module ptp_tsq_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 96
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_eff;
  logic          pop_eff;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  assign head     = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_eff) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_eff) wptr <= wptr + PTR_ONE;
      if (pop_eff)  rptr <= rptr + PTR_ONE;
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ptp_up_regs.sv
// CPU register slave for the PTP RTC: time-set/period/adjust registers, RTC
// command strobes, a snapshot request handshake and the TSU timestamp queue.
module ptp_up_regs
  import ptp_pkg::*;
#(
  parameter int TSQ_DEPTH = 16,
  parameter int TSQ_AW    = 4
) (
  input  logic        up_clk,
  input  logic        rst_n,
  input  logic        up_wr,
  input  logic        up_rd,
  input  logic [7:0]  up_addr,
  input  logic [31:0] up_data_wr,
  output logic [31:0] up_data_rd,
  output logic        rtc_set_stb,
  output logic        rtc_adj_stb,
  output logic [47:0] rtc_time_sec,
  output logic [29:0] rtc_time_ns,
  output logic [31:0] rtc_period,
  output logic [31:0] rtc_adj_ns,
  output logic        rtc_snap_req,
  input  logic        rtc_snap_ack,
  input  logic [47:0] rtc_snap_sec,
  input  logic [29:0] rtc_snap_ns,
  input  logic        ts_valid,
  input  logic [95:0] ts_data
);

  // Bus handshake: up_wr/up_rd are levels; an access happens once on the
  // 0->1 transition. Reads are answered one cycle after the edge so a write
  // taken on the same edge is already visible in the returned data.
  logic        wr_q, rd_q, rd_pend;
  logic        wr_edge, rd_edge;
  logic [7:0]  reg_addr, rd_addr_q;
  logic [31:0] rd_mux;

  logic [15:0] tsec_h;
  logic [31:0] tsec_l;
  logic [47:0] ssec;
  logic [29:0] sns;
  logic        ovf;
  logic        ctrl_wr, snap_cmd, snap_load, ovf_clr;

  snap_state_t state, state_nx;

  logic [TS_W-1:0] tsq_head;
  logic [TSQ_AW:0] tsq_count;
  logic            tsq_full, tsq_empty, tsq_pop;

  logic unused_bits;
  assign unused_bits = ^{up_addr[1:0], tsq_head[31:30]};

  assign reg_addr  = {up_addr[7:2], 2'b00};
  assign wr_edge   = up_wr && !wr_q;
  assign rd_edge   = up_rd && !rd_q;
  assign ctrl_wr   = wr_edge && (reg_addr == A_CTRL);
  assign snap_cmd  = ctrl_wr && up_data_wr[CTRL_SNAP];
  assign snap_load = (state == SNAP_REQ) && rtc_snap_ack;
  assign ovf_clr   = wr_edge && (reg_addr == A_TSQ_STAT) && up_data_wr[STAT_OVF];
  assign tsq_pop   = rd_pend && (rd_addr_q == A_TSQ_W2) && !tsq_empty;

  assign rtc_time_sec = {tsec_h, tsec_l};

  always_ff @(posedge up_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      rd_pend    <= 1'b0;
      rd_addr_q  <= '0;
      up_data_rd <= '0;
    end else begin
      wr_q    <= up_wr;
      rd_q    <= up_rd;
      rd_pend <= rd_edge;
      if (rd_edge) rd_addr_q  <= reg_addr;
      if (rd_pend) up_data_rd <= rd_mux;
    end
  end

  always_ff @(posedge up_clk or negedge rst_n) begin
    if (!rst_n) begin
      tsec_h      <= '0;
      tsec_l      <= '0;
      rtc_time_ns <= '0;
      rtc_period  <= PERIOD_RST;
      rtc_adj_ns  <= '0;
    end else if (wr_edge) begin
      case (reg_addr)
        A_TSEC_H: tsec_h      <= up_data_wr[15:0];
        A_TSEC_L: tsec_l      <= up_data_wr;
        A_TNS:    rtc_time_ns <= up_data_wr[29:0];
        A_PERIOD: rtc_period  <= up_data_wr;
        A_ADJ:    rtc_adj_ns  <= up_data_wr;
        default:  ;
      endcase
    end
  end

  // Strobes are registered so they are clean one-cycle pulses after the edge
  always_ff @(posedge up_clk or negedge rst_n) begin
    if (!rst_n) begin
      rtc_set_stb <= 1'b0;
      rtc_adj_stb <= 1'b0;
    end else begin
      rtc_set_stb <= ctrl_wr && up_data_wr[CTRL_SET];
      rtc_adj_stb <= ctrl_wr && up_data_wr[CTRL_ADJ];
    end
  end

  // Snapshot FSM: state register / next state / outputs
  always_ff @(posedge up_clk or negedge rst_n) begin
    if (!rst_n) state <= SNAP_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SNAP_IDLE: if (snap_cmd)     state_nx = SNAP_REQ;
      SNAP_REQ:  if (rtc_snap_ack) state_nx = SNAP_IDLE;
      default:                     state_nx = SNAP_IDLE;
    endcase
  end

  always_comb begin
    rtc_snap_req = (state == SNAP_REQ);
  end

  always_ff @(posedge up_clk or negedge rst_n) begin
    if (!rst_n) begin
      ssec <= '0;
      sns  <= '0;
    end else if (snap_load) begin
      ssec <= rtc_snap_sec;
      sns  <= rtc_snap_ns;
    end
  end

  // A push that is dropped because the queue is full sets the sticky flag;
  // setting wins over a clear issued in the same cycle.
  always_ff @(posedge up_clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else begin
      if (ovf_clr) ovf <= 1'b0;
      if (ts_valid && tsq_full && !tsq_pop) ovf <= 1'b1;
    end
  end

  ptp_tsq_fifo #(
    .DEPTH (TSQ_DEPTH),
    .AW    (TSQ_AW),
    .W     (TS_W)
  ) u_tsq (
    .clk       (up_clk),
    .rst_n     (rst_n),
    .push      (ts_valid),
    .push_data (ts_data),
    .pop       (tsq_pop),
    .head      (tsq_head),
    .full      (tsq_full),
    .empty     (tsq_empty),
    .count     (tsq_count)
  );

  always_comb begin
    rd_mux = '0;
    case (rd_addr_q)
      A_CTRL:     rd_mux[CTRL_BUSY] = (state == SNAP_REQ);
      A_TSEC_H:   rd_mux[15:0] = tsec_h;
      A_TSEC_L:   rd_mux = tsec_l;
      A_TNS:      rd_mux[29:0] = rtc_time_ns;
      A_PERIOD:   rd_mux = rtc_period;
      A_ADJ:      rd_mux = rtc_adj_ns;
      A_SSEC_H:   rd_mux[15:0] = ssec[47:32];
      A_SSEC_L:   rd_mux = ssec[31:0];
      A_SNS:      rd_mux[29:0] = sns;
      A_TSQ_STAT: begin
        rd_mux[TSQ_AW:0] = tsq_count;
        rd_mux[STAT_OVF] = ovf;
      end
      A_TSQ_W0: if (!tsq_empty)
        rd_mux = {tsq_head[TS_SEQ_LSB +: 16], tsq_head[TS_SEC_LSB+32 +: 16]};
      A_TSQ_W1: if (!tsq_empty) rd_mux = tsq_head[TS_SEC_LSB +: 32];
      A_TSQ_W2: if (!tsq_empty) rd_mux = {2'b00, tsq_head[TS_NS_LSB +: TS_NS_W]};
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_ptp_up_regs.sv
// Self-checking bench for ptp_up_regs: register-map model with a queue-based
// timestamp FIFO, per-cycle output compare and directed register accesses.
module tb_ptp_up_regs;

  logic        up_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        up_wr = 1'b0;
  logic        up_rd = 1'b0;
  logic [7:0]  up_addr = '0;
  logic [31:0] up_data_wr = '0;
  logic [31:0] up_data_rd;
  logic        rtc_set_stb, rtc_adj_stb, rtc_snap_req;
  logic [47:0] rtc_time_sec;
  logic [29:0] rtc_time_ns;
  logic [31:0] rtc_period, rtc_adj_ns;
  logic        rtc_snap_ack = 1'b0;
  logic [47:0] rtc_snap_sec = '0;
  logic [29:0] rtc_snap_ns = '0;
  logic        ts_valid = 1'b0;
  logic [95:0] ts_data = '0;

  ptp_up_regs #(.TSQ_DEPTH(16), .TSQ_AW(4)) dut (
    .up_clk       (up_clk),
    .rst_n        (rst_n),
    .up_wr        (up_wr),
    .up_rd        (up_rd),
    .up_addr      (up_addr),
    .up_data_wr   (up_data_wr),
    .up_data_rd   (up_data_rd),
    .rtc_set_stb  (rtc_set_stb),
    .rtc_adj_stb  (rtc_adj_stb),
    .rtc_time_sec (rtc_time_sec),
    .rtc_time_ns  (rtc_time_ns),
    .rtc_period   (rtc_period),
    .rtc_adj_ns   (rtc_adj_ns),
    .rtc_snap_req (rtc_snap_req),
    .rtc_snap_ack (rtc_snap_ack),
    .rtc_snap_sec (rtc_snap_sec),
    .rtc_snap_ns  (rtc_snap_ns),
    .ts_valid     (ts_valid),
    .ts_data      (ts_data)
  );

  // ---------------- clock ----------------
  always #5 up_clk = ~up_clk;

  // ---------------- model ----------------
  localparam int DEPTH = 16;
  logic [47:0] m_tsec;
  logic [29:0] m_tns;
  logic [31:0] m_period, m_adj;
  logic        m_busy, m_ovf;
  logic [47:0] m_ssec;
  logic [29:0] m_sns;
  logic [95:0] tsq[$];
  int          set_at = -1;
  int          adj_at = -1;
  int          neg_cnt = 0;

  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_tsec = '0; m_tns = '0; m_period = 32'h0800_0000; m_adj = '0;
    m_busy = 1'b0; m_ovf = 1'b0; m_ssec = '0; m_sns = '0;
    tsq.delete();
    set_at = -1; adj_at = -1;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d);
    case (a & 8'hFC)
      8'h00: begin
        if (d[0]) set_at = neg_cnt + 1;
        if (d[1]) adj_at = neg_cnt + 1;
        if (d[2] && !m_busy) m_busy = 1'b1;
      end
      8'h10: m_tsec[47:32] = d[15:0];
      8'h14: m_tsec[31:0] = d;
      8'h18: m_tns = d[29:0];
      8'h1C: m_period = d;
      8'h20: m_adj = d;
      8'h30: if (d[31]) m_ovf = 1'b0;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [95:0] h;
    logic [31:0] r;
    h = (tsq.size() > 0) ? tsq[0] : 96'h0;
    r = 32'h0;
    case (a & 8'hFC)
      8'h00: r = m_busy ? 32'h8 : 32'h0;
      8'h10: r = {16'h0, m_tsec[47:32]};
      8'h14: r = m_tsec[31:0];
      8'h18: r = {2'b00, m_tns};
      8'h1C: r = m_period;
      8'h20: r = m_adj;
      8'h24: r = {16'h0, m_ssec[47:32]};
      8'h28: r = m_ssec[31:0];
      8'h2C: r = {2'b00, m_sns};
      8'h30: r = {m_ovf, 31'(tsq.size())};
      8'h34: r = h[95:64];
      8'h38: r = h[63:32];
      8'h3C: r = {2'b00, h[29:0]};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [95:0] mk_ts(input logic [15:0] seq, input logic [47:0] sec,
                                        input logic [29:0] ns);
    return {seq, sec, 2'b00, ns};
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge up_clk) begin
    neg_cnt++;
    if (rst_n) begin
      check("set_stb",  64'(rtc_set_stb),  64'(neg_cnt == set_at));
      check("adj_stb",  64'(rtc_adj_stb),  64'(neg_cnt == adj_at));
      check("time_sec", 64'(rtc_time_sec), 64'(m_tsec));
      check("time_ns",  64'(rtc_time_ns),  64'(m_tns));
      check("period",   64'(rtc_period),   64'(m_period));
      check("adj_ns",   64'(rtc_adj_ns),   64'(m_adj));
      check("snap_req", 64'(rtc_snap_req), 64'(m_busy));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int hold);
    @(posedge up_clk); #1;
    up_wr = 1'b1; up_addr = a; up_data_wr = d;
    @(posedge up_clk);
    model_write(a, d);
    repeat (hold - 1) @(posedge up_clk);
    #1 up_wr = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input bit use_lit, input logic [31:0] lit,
                         input string name);
    @(posedge up_clk); #1;
    up_rd = 1'b1; up_addr = a;
    @(posedge up_clk); #1;
    up_rd = 1'b0;
    exp_q.push_back(use_lit ? lit : model_read(a));
    @(posedge up_clk);
    if (((a & 8'hFC) == 8'h3C) && (tsq.size() > 0)) void'(tsq.pop_front());
    #1 check(name, 64'(up_data_rd), 64'(exp_q.pop_front()));
  endtask

  task automatic do_wr_rd(input logic [7:0] a, input logic [31:0] d);
    @(posedge up_clk); #1;
    up_wr = 1'b1; up_rd = 1'b1; up_addr = a; up_data_wr = d;
    @(posedge up_clk);
    model_write(a, d);
    exp_q.push_back(model_read(a));
    #1 up_wr = 1'b0; up_rd = 1'b0;
    @(posedge up_clk);
    #1 check("wr_rd_same_edge", 64'(up_data_rd), 64'(exp_q.pop_front()));
  endtask

  task automatic push_ts(input logic [95:0] d);
    @(posedge up_clk); #1;
    ts_valid = 1'b1; ts_data = d;
    @(posedge up_clk);
    if (tsq.size() < DEPTH) tsq.push_back(d);
    else m_ovf = 1'b1;
    #1 ts_valid = 1'b0;
  endtask

  // W2 read whose pop lands in the same cycle as a TSU push
  task automatic rd_push(input logic [95:0] d, input string name);
    @(posedge up_clk); #1;
    up_rd = 1'b1; up_addr = 8'h3C;
    @(posedge up_clk);
    exp_q.push_back(model_read(8'h3C));
    #1 up_rd = 1'b0; ts_valid = 1'b1; ts_data = d;
    @(posedge up_clk);
    if (tsq.size() > 0) void'(tsq.pop_front());
    if (tsq.size() < DEPTH) tsq.push_back(d);
    else m_ovf = 1'b1;
    #1 ts_valid = 1'b0;
    check(name, 64'(up_data_rd), 64'(exp_q.pop_front()));
  endtask

  task automatic do_ack(input logic [47:0] sec, input logic [29:0] ns);
    @(posedge up_clk); #1;
    rtc_snap_ack = 1'b1; rtc_snap_sec = sec; rtc_snap_ns = ns;
    @(posedge up_clk);
    if (m_busy) begin
      m_ssec = sec; m_sns = ns; m_busy = 1'b0;
    end
    #1 rtc_snap_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge up_clk);
    #1 rst_n = 1'b1;

    // reset state
    check("rst_period", 64'(rtc_period), 64'h0800_0000);
    check("rst_time_sec", 64'(rtc_time_sec), 64'h0);
    check("rst_snap_req", 64'(rtc_snap_req), 64'h0);
    do_read(8'h1C, 1'b1, 32'h0800_0000, "rd_period_rst");
    do_read(8'h00, 1'b1, 32'h0, "rd_ctrl_rst");
    do_read(8'h30, 1'b1, 32'h0, "rd_stat_rst");

    // time set and command strobes
    do_write(8'h10, 32'hFFFF_ABCD, 1);
    do_write(8'h14, 32'h1234_5678, 1);
    do_write(8'h18, 32'd999_999_999, 1);
    do_write(8'h00, 32'h1, 1);
    repeat (2) @(posedge up_clk);
    #1 check("time_ns_lit", 64'(rtc_time_ns), 64'd999_999_999);
    check("time_sec_lit", 64'(rtc_time_sec), 64'hABCD_1234_5678);
    do_read(8'h10, 1'b1, 32'h0000_ABCD, "rd_tsec_h");
    do_read(8'h13, 1'b0, 32'h0, "rd_tsec_h_unaligned");
    do_write(8'h18, 32'hFFFF_FFFF, 1);
    do_read(8'h18, 1'b1, 32'h3FFF_FFFF, "rd_tns_mask");
    do_write(8'h1C, 32'h0A00_0000, 1);
    do_write(8'h20, 32'hFFFF_FF9C, 1);
    do_read(8'h20, 1'b0, 32'h0, "rd_adj");
    do_write(8'h44, 32'hDEAD_BEEF, 1);
    do_read(8'h44, 1'b1, 32'h0, "rd_unmapped_44");
    do_read(8'h04, 1'b1, 32'h0, "rd_unmapped_04");

    // held write strobe acts once; both command bits pulse together
    do_write(8'h00, 32'h2, 4);
    repeat (2) @(posedge up_clk);
    do_write(8'h00, 32'h3, 1);
    repeat (2) @(posedge up_clk);

    // snapshot with delayed ack
    do_write(8'h00, 32'h4, 1);
    do_read(8'h00, 1'b1, 32'h8, "rd_ctrl_busy");
    do_write(8'h00, 32'h5, 1);
    repeat (5) @(posedge up_clk);
    do_ack(48'h1_0000_0002, 30'd123_456_789);
    do_read(8'h00, 1'b1, 32'h0, "rd_ctrl_idle");
    do_read(8'h24, 1'b1, 32'h1, "rd_ssec_h");
    do_read(8'h28, 1'b1, 32'h2, "rd_ssec_l");
    do_read(8'h2C, 1'b0, 32'h0, "rd_sns");
    do_ack(48'hFFFF_FFFF_FFFF, 30'h5);
    do_read(8'h28, 1'b1, 32'h2, "rd_ssec_l_idle_ack");

    // timestamp queue: overfill, drain in order
    for (int i = 0; i < 17; i++)
      push_ts(mk_ts(16'hA000 + 16'(i), {16'h0001, 32'hC000_0000 + 32'(i)}, 30'(100 + i)));
    do_read(8'h30, 1'b1, 32'h8000_0010, "rd_stat_full");
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        do_read(8'h34, 1'b1, 32'hA000_0001, "rd_w0_first");
        do_read(8'h38, 1'b1, 32'hC000_0000, "rd_w1_first");
        do_read(8'h3C, 1'b1, 32'd100, "rd_w2_first");
      end else if (i == 15) begin
        do_read(8'h34, 1'b0, 32'h0, "rd_w0");
        do_read(8'h38, 1'b0, 32'h0, "rd_w1");
        do_read(8'h3C, 1'b1, 32'd115, "rd_w2_last");
      end else begin
        do_read(8'h34, 1'b0, 32'h0, "rd_w0");
        do_read(8'h38, 1'b0, 32'h0, "rd_w1");
        do_read(8'h3C, 1'b0, 32'h0, "rd_w2");
      end
    end
    do_read(8'h30, 1'b1, 32'h8000_0000, "rd_stat_drained");
    do_read(8'h3C, 1'b1, 32'h0, "rd_w2_empty");
    do_read(8'h30, 1'b1, 32'h8000_0000, "rd_stat_after_empty_pop");
    do_write(8'h30, 32'h8000_0000, 1);
    do_read(8'h30, 1'b1, 32'h0, "rd_stat_ovf_clr");

    // push+pop same cycle: empty then full
    rd_push(mk_ts(16'h0B01, 48'h0000_0000_0055, 30'd7), "rd_push_empty");
    do_read(8'h30, 1'b1, 32'h1, "rd_stat_push_only");
    for (int i = 0; i < 15; i++)
      push_ts(mk_ts(16'h0C00 + 16'(i), 48'(i), 30'(200 + i)));
    rd_push(mk_ts(16'h0D00, 48'h0000_0000_0099, 30'd9), "rd_push_full");
    do_read(8'h30, 1'b1, 32'h10, "rd_stat_full_no_ovf");
    do_read(8'h34, 1'b0, 32'h0, "rd_w0_after_swap");

    // write and read on the same edge
    do_wr_rd(8'h20, 32'h1357_9BDF);

    // async reset while a snapshot is pending
    do_write(8'h00, 32'h4, 1);
    repeat (2) @(posedge up_clk);
    #3 rst_n = 1'b0;
    #1 check("req_async_drop", 64'(rtc_snap_req), 64'h0);
    model_reset();
    @(posedge up_clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge up_clk);
    do_read(8'h30, 1'b1, 32'h0, "rd_stat_post_rst");
    do_read(8'h00, 1'b1, 32'h0, "rd_ctrl_post_rst");
    do_read(8'h1C, 1'b1, 32'h0800_0000, "rd_period_post_rst");
    do_read(8'h14, 1'b1, 32'h0, "rd_tsec_l_post_rst");

    repeat (2) @(posedge up_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
